// File: rtl/hazard_forward_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl_if
//
// Bundles the pipeline-side signals of the hazard / forwarding controller.
//   master : pipeline side, drives register addresses, control bits and
//            dmem_ready; receives forwarding selects, enables and mem_err.
//   slave  : the hazard controller itself.
//
// Signals (NUM_SRC operands, REG_AW-bit register addresses):
//   id_rs, id_rs_used          ID-stage source addresses / operand-used mask
//   ex_rs                      EX-stage source addresses
//   id_ex_rd, id_ex_memread    destination and load flag of the EX instruction
//   ex_mem_rd, ex_mem_regwrite destination and RegWrite of the MEM instruction
//   ex_mem_memread/_memwrite   load / store in MEM
//   mem_wb_rd, mem_wb_regwrite destination and RegWrite of the WB instruction
//   dmem_ready                 data memory completes the MEM access this cycle
//   forward_sel                per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write, if_id_write      front-end enables
//   id_ex_bubble               load a NOP into ID/EX
//   pipe_hold                  freeze ID/EX, EX/MEM and MEM/WB
//   mem_err                    sticky data-memory timeout flag
// -----------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5
);
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [NUM_SRC*REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0]         id_ex_rd;
   logic                      id_ex_memread;
   logic [REG_AW-1:0]         ex_mem_rd;
   logic                      ex_mem_regwrite;
   logic                      ex_mem_memread;
   logic                      ex_mem_memwrite;
   logic [REG_AW-1:0]         mem_wb_rd;
   logic                      mem_wb_regwrite;
   logic                      dmem_ready;
   logic [NUM_SRC*2-1:0]      forward_sel;
   logic                      pc_write;
   logic                      if_id_write;
   logic                      id_ex_bubble;
   logic                      pipe_hold;
   logic                      mem_err;

   modport master (
      output id_rs, id_rs_used, ex_rs, id_ex_rd, id_ex_memread,
             ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
             mem_wb_rd, mem_wb_regwrite, dmem_ready,
      input  forward_sel, pc_write, if_id_write, id_ex_bubble, pipe_hold,
             mem_err
   );

   modport slave (
      input  id_rs, id_rs_used, ex_rs, id_ex_rd, id_ex_memread,
             ex_mem_rd, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
             mem_wb_rd, mem_wb_regwrite, dmem_ready,
      output forward_sel, pc_write, if_id_write, id_ex_bubble, pipe_hold,
             mem_err
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard unit for a 5-stage RISC-V pipeline:
//   - operand forwarding for NUM_SRC sources (EX/MEM beats MEM/WB),
//   - load-use stall of LOAD_LAT bubbles,
//   - pipeline freeze while the data memory has not completed (mem_busy),
//     with a sticky timeout flag after WAIT_TIMEOUT wait cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   hz     hazard_forward_ctrl_if.slave (see interface file for signal list)
//   stall_cycles / hold_cycles / fwd_events  (only with HAZARD_PERF_EN)
//          saturating 32-bit counts of bubble cycles, hold cycles and cycles
//          with any forwarding active.
//
// Optional feature macro: HAZARD_PERF_EN.
// Control outputs are Mealy: they respond in the same cycle as the hazard.
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
   parameter int NUM_SRC      = 2,
   parameter int REG_AW       = 5,
   parameter int LOAD_LAT     = 1,
   parameter int WAIT_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_forward_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           hold_cycles,
   output logic [31:0]           fwd_events
`endif
);

   localparam int                WCNT_W   = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                ret_lu_q, ret_lu_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                mem_err_q, mem_err_d;

   logic [NUM_SRC*2-1:0] fwd;
   logic                 lu_hit;
   logic                 mem_busy;
   logic                 pc_write, if_id_write, bubble, hold;
   state_t               eff_state;

   // ---------------------------------------------------------------- forwarding
   always_comb begin
      // NOTE: every signal driven in always_comb gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hz.ex_mem_regwrite && hz.ex_mem_rd != '0 &&
             hz.ex_mem_rd == hz.ex_rs[i*REG_AW +: REG_AW])
            fwd[i*2 +: 2] = 2'b10;
         else if (hz.mem_wb_regwrite && hz.mem_wb_rd != '0 &&
                  hz.mem_wb_rd == hz.ex_rs[i*REG_AW +: REG_AW])
            fwd[i*2 +: 2] = 2'b01;
      end
   end

   // ------------------------------------------------------- hazard detection
   always_comb begin
      lu_hit = 1'b0;
      if (hz.id_ex_memread && hz.id_ex_rd != '0) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.id_rs_used[i] && hz.id_rs[i*REG_AW +: REG_AW] == hz.id_ex_rd)
               lu_hit = 1'b1;
         end
      end
   end

   assign mem_busy = (hz.ex_mem_memread | hz.ex_mem_memwrite) & ~hz.dmem_ready;

   // ------------------------------------------------ next state and outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ret_lu_d    = ret_lu_q;
      wcnt_d      = '0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      bubble      = 1'b0;
      hold        = 1'b0;

      // The cycle memory completes, MEM_WAIT behaves exactly like the state
      // it interrupted, so a resumed load-use stall still spends its
      // remaining bubbles and the total stays LOAD_LAT.
      eff_state = state_q;
      if (state_q == MEM_WAIT && !mem_busy)
         eff_state = ret_lu_q ? LU_STALL : RUN;

      if (mem_busy) begin
         // Memory stall outranks everything; cnt is left untouched.
         hold        = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         state_d     = MEM_WAIT;
         if (state_q == MEM_WAIT) begin
            wcnt_d = (wcnt_q == WAIT_MAX) ? wcnt_q : wcnt_q + 1'b1;
         end else begin
            wcnt_d   = WCNT_W'(1);
            ret_lu_d = (state_q == LU_STALL);
         end
      end else begin
         ret_lu_d = 1'b0;
         case (eff_state)
            LU_STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               bubble      = 1'b1;
               cnt_d       = cnt_q - 3'd1;
               state_d     = (cnt_q == 3'd1) ? RUN : LU_STALL;
            end
            default: begin
               state_d = RUN;
               if (lu_hit) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  bubble      = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = LU_STALL;
                     cnt_d   = 3'(LOAD_LAT - 1);
                  end
               end
            end
         endcase
      end

      mem_err_d = mem_err_q | (wcnt_d == WAIT_MAX);
   end

   // ------------------------------------------------------------- state regs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         ret_lu_q  <= 1'b0;
         wcnt_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ret_lu_q  <= ret_lu_d;
         wcnt_q    <= wcnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign hz.forward_sel  = fwd;
   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.id_ex_bubble = bubble;
   assign hz.pipe_hold    = hold;
   assign hz.mem_err      = mem_err_q;

`ifdef HAZARD_PERF_EN
   // ------------------------------------------------- performance counters
   logic [31:0] stall_q, hold_q, fwd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         hold_q  <= '0;
         fwd_q   <= '0;
      end else begin
         if (bubble && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (hold   && hold_q  != '1) hold_q  <= hold_q  + 32'd1;
         if ((|fwd) && fwd_q   != '1) fwd_q   <= fwd_q   + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign hold_cycles  = hold_q;
   assign fwd_events   = fwd_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Two controllers share one set of pipeline inputs:
//   dut_a : LOAD_LAT=1, WAIT_TIMEOUT=8
//   dut_b : LOAD_LAT=3, WAIT_TIMEOUT=8
// A vector table covers forwarding and single-cycle load-use decisions on
// dut_a; hand-written sequences cover multi-cycle stalls, memory waits,
// timeout and reset behaviour.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

   localparam int NUM_SRC = 2;
   localparam int REG_AW  = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [9:0] id_rs, ex_rs;
   logic [1:0] id_rs_used;
   logic [4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
   logic       id_ex_memread, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
   logic       mem_wb_regwrite, dmem_ready;

   hazard_forward_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) if_a ();
   hazard_forward_ctrl_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) if_b ();

   assign if_a.id_rs = id_rs;                   assign if_b.id_rs = id_rs;
   assign if_a.id_rs_used = id_rs_used;         assign if_b.id_rs_used = id_rs_used;
   assign if_a.ex_rs = ex_rs;                   assign if_b.ex_rs = ex_rs;
   assign if_a.id_ex_rd = id_ex_rd;             assign if_b.id_ex_rd = id_ex_rd;
   assign if_a.id_ex_memread = id_ex_memread;   assign if_b.id_ex_memread = id_ex_memread;
   assign if_a.ex_mem_rd = ex_mem_rd;           assign if_b.ex_mem_rd = ex_mem_rd;
   assign if_a.ex_mem_regwrite = ex_mem_regwrite;
   assign if_b.ex_mem_regwrite = ex_mem_regwrite;
   assign if_a.ex_mem_memread = ex_mem_memread; assign if_b.ex_mem_memread = ex_mem_memread;
   assign if_a.ex_mem_memwrite = ex_mem_memwrite;
   assign if_b.ex_mem_memwrite = ex_mem_memwrite;
   assign if_a.mem_wb_rd = mem_wb_rd;           assign if_b.mem_wb_rd = mem_wb_rd;
   assign if_a.mem_wb_regwrite = mem_wb_regwrite;
   assign if_b.mem_wb_regwrite = mem_wb_regwrite;
   assign if_a.dmem_ready = dmem_ready;         assign if_b.dmem_ready = dmem_ready;

`ifdef HAZARD_PERF_EN
   logic [31:0] a_stall, a_hold, a_fwd, b_stall, b_hold, b_fwd;
`endif

   hazard_forward_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(1), .WAIT_TIMEOUT(8))
   dut_a (
      .clk   (clk),
      .reset (reset),
      .hz    (if_a)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles (a_stall),
      .hold_cycles  (a_hold),
      .fwd_events   (a_fwd)
`endif
   );

   hazard_forward_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(3), .WAIT_TIMEOUT(8))
   dut_b (
      .clk   (clk),
      .reset (reset),
      .hz    (if_b)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles (b_stall),
      .hold_cycles  (b_hold),
      .fwd_events   (b_fwd)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      id_rs = '0; ex_rs = '0; id_rs_used = '0;
      id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
      id_ex_memread = 1'b0; ex_mem_regwrite = 1'b0;
      ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
      mem_wb_regwrite = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   // Checks the four control enables of one controller against expectations.
   task automatic check_ctl(input string tag, input logic pcw, input logic ifw,
                            input logic bub, input logic hld, input logic use_b);
      if (use_b) begin
         check({tag, " pc_write"},     32'(if_b.pc_write),     32'(pcw));
         check({tag, " if_id_write"},  32'(if_b.if_id_write),  32'(ifw));
         check({tag, " id_ex_bubble"}, 32'(if_b.id_ex_bubble), 32'(bub));
         check({tag, " pipe_hold"},    32'(if_b.pipe_hold),    32'(hld));
      end else begin
         check({tag, " pc_write"},     32'(if_a.pc_write),     32'(pcw));
         check({tag, " if_id_write"},  32'(if_a.if_id_write),  32'(ifw));
         check({tag, " id_ex_bubble"}, 32'(if_a.id_ex_bubble), 32'(bub));
         check({tag, " pipe_hold"},    32'(if_a.pipe_hold),    32'(hld));
      end
   endtask

   typedef struct {
      logic [9:0] ex_rs;
      logic [4:0] ex_mem_rd;
      logic       ex_mem_rw;
      logic [4:0] mem_wb_rd;
      logic       mem_wb_rw;
      logic [9:0] id_rs;
      logic [1:0] used;
      logic [4:0] id_ex_rd;
      logic       ld;
      logic [3:0] exp_fwd;
      logic       exp_stall;
   } vec_t;

   vec_t vecs[12];

   initial begin
      // ex_rs / id_rs packed as {operand1, operand0}
      vecs[0]  = '{{5'd0, 5'd5}, 5'd5, 1'b1, 5'd5, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b0010, 1'b0};
      vecs[1]  = '{{5'd0, 5'd5}, 5'd0, 1'b1, 5'd5, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b0001, 1'b0};
      vecs[2]  = '{{5'd0, 5'd5}, 5'd5, 1'b0, 5'd5, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b0001, 1'b0};
      vecs[3]  = '{{5'd4, 5'd3}, 5'd4, 1'b1, 5'd3, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b1001, 1'b0};
      vecs[4]  = '{10'd0,        5'd0, 1'b1, 5'd0, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b0000, 1'b0};
      vecs[5]  = '{{5'd6, 5'd0}, 5'd0, 1'b0, 5'd6, 1'b0, 10'd0, 2'b00, 5'd0, 1'b0, 4'b0000, 1'b0};
      vecs[6]  = '{10'd0, 5'd0, 1'b0, 5'd0, 1'b0, {5'd7, 5'd2},  2'b10, 5'd7,  1'b1, 4'b0000, 1'b1};
      vecs[7]  = '{10'd0, 5'd0, 1'b0, 5'd0, 1'b0, {5'd7, 5'd2},  2'b01, 5'd7,  1'b1, 4'b0000, 1'b0};
      vecs[8]  = '{10'd0, 5'd0, 1'b0, 5'd0, 1'b0, {5'd0, 5'd0},  2'b01, 5'd0,  1'b1, 4'b0000, 1'b0};
      vecs[9]  = '{10'd0, 5'd0, 1'b0, 5'd0, 1'b0, {5'd7, 5'd2},  2'b10, 5'd7,  1'b0, 4'b0000, 1'b0};
      vecs[10] = '{{5'd0, 5'd9}, 5'd9, 1'b1, 5'd0, 1'b0, {5'd1, 5'd12}, 2'b11, 5'd12, 1'b1, 4'b0010, 1'b1};
      vecs[11] = '{{5'd8, 5'd8}, 5'd8, 1'b1, 5'd8, 1'b1, 10'd0, 2'b00, 5'd0, 1'b0, 4'b1010, 1'b0};

      // ------------------------------------------------ reset state
      do_reset();
      @(negedge clk);
      check("rst fwd_a", 32'(if_a.forward_sel), 32'h0);
      check("rst fwd_b", 32'(if_b.forward_sel), 32'h0);
      check("rst mem_err_a", 32'(if_a.mem_err), 32'h0);
      check_ctl("rst_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("rst_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // ------------------------------------------------ vector table (dut_a)
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         idle();
         ex_rs = vecs[i].ex_rs;
         ex_mem_rd = vecs[i].ex_mem_rd;  ex_mem_regwrite = vecs[i].ex_mem_rw;
         mem_wb_rd = vecs[i].mem_wb_rd;  mem_wb_regwrite = vecs[i].mem_wb_rw;
         id_rs = vecs[i].id_rs;          id_rs_used = vecs[i].used;
         id_ex_rd = vecs[i].id_ex_rd;    id_ex_memread = vecs[i].ld;
         @(negedge clk);
         check($sformatf("vec%0d forward_sel", i), 32'(if_a.forward_sel), 32'(vecs[i].exp_fwd));
         check_ctl($sformatf("vec%0d", i), ~vecs[i].exp_stall, ~vecs[i].exp_stall,
                   vecs[i].exp_stall, 1'b0, 1'b0);
      end

      // ------------------------------------------------ LOAD_LAT=1: exactly one bubble
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_rs_used = 2'b10;
      @(negedge clk);
      check_ctl("ll1 c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
      idle();
      @(negedge clk);
      check_ctl("ll1 c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // ------------------------------------------------ LOAD_LAT=3: three bubbles
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_ctl($sformatf("ll3 c%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         next_cycle();
         idle();
      end
      @(negedge clk);
      check_ctl("ll3 c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_PERF_EN
      check("ll3 stall_cycles", b_stall, 32'd3);
      check("ll3 hold_cycles",  b_hold,  32'd0);
`endif

      // ------------------------------------------------ LOAD_LAT=3 interrupted by memory
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
      @(negedge clk);
      check_ctl("lum c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      next_cycle();
      idle();
      ex_mem_memread = 1'b1; dmem_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check_ctl($sformatf("lum c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         next_cycle();
      end
      idle();
      for (int c = 5; c <= 6; c++) begin
         @(negedge clk);
         check_ctl($sformatf("lum c%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         next_cycle();
      end
      @(negedge clk);
      check_ctl("lum c7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // ------------------------------------------------ mem_busy outranks lu_hit
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd3; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
      ex_mem_memread = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      check_ctl("prio", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // ------------------------------------------------ timeout on a store (WAIT_TIMEOUT=8)
      do_reset();
      ex_mem_memwrite = 1'b1; dmem_ready = 1'b0;
      ex_rs = {5'd0, 5'd5}; ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("tmo c%0d pipe_hold", c), 32'(if_a.pipe_hold), 32'd1);
         check($sformatf("tmo c%0d mem_err", c), 32'(if_a.mem_err), (c >= 8) ? 32'd1 : 32'd0);
         if (c == 3)
            check("tmo fwd in hold", 32'(if_a.forward_sel), 32'b10);
         next_cycle();
      end
      idle();
      @(negedge clk);
      check_ctl("tmo done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("tmo sticky0", 32'(if_a.mem_err), 32'd1);
      next_cycle();
      @(negedge clk);
      check("tmo sticky1", 32'(if_a.mem_err), 32'd1);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("tmo reset mem_err", 32'(if_a.mem_err), 32'd0);

      // ------------------------------------------------ reset in the middle of LU_STALL
      do_reset();
      id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      @(negedge clk);
      check_ctl("mrst c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      next_cycle();
      idle();
      @(negedge clk);
      check_ctl("mrst c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_ctl("mrst c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_PERF_EN
      check("mrst stall_cycles", b_stall, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Next-generation hazard block for the 5-stage RISC-V pipeline: combines operand forwarding for NUM_SRC source operands, load-use stall insertion with a configurable bubble count, and a pipeline freeze FSM for a data memory that has a ready handshake.
- Sits beside the ID/EX and EX/MEM pipeline registers.
- Drives the EX operand muxes and the PC, IF/ID, ID/EX and later-stage register enables.

Parameters:
- NUM_SRC, 2, source operands per instruction (2 or 3).
- REG_AW, 5, register address width.
- LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..4).
- WAIT_TIMEOUT, 64, MEM_WAIT cycles before mem_err is raised (>=2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  NUM_SRC*REG_AW  ID-stage source addresses; operand i at [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  bit i: ID instruction reads operand i.
- ex_rs  in  NUM_SRC*REG_AW  EX-stage source addresses.
- id_ex_rd  in  REG_AW  destination address in EX.
- id_ex_memread  in  1  EX instruction is a load.
- ex_mem_rd  in  REG_AW  destination address in MEM.
- ex_mem_regwrite  in  1  RegWrite in MEM.
- ex_mem_memread  in  1  load in MEM.
- ex_mem_memwrite  in  1  store in MEM.
- mem_wb_rd  in  REG_AW  destination address in WB.
- mem_wb_regwrite  in  1  RegWrite in WB.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- forward_sel  out  NUM_SRC*2  per operand: 00 register file, 10 EX/MEM, 01 MEM/WB.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- Forwarding (combinational, per operand i):
  - 10 if ex_mem_regwrite, ex_mem_rd!=0 and ex_mem_rd==ex_rs[i].
  - Otherwise 01 if mem_wb_regwrite, mem_wb_rd!=0 and mem_wb_rd==ex_rs[i].
  - Otherwise 00.
  - EX/MEM always has priority over MEM/WB.
  - Forwarding is evaluated in every state, including hold.
- Definitions:
  - lu_hit = id_ex_memread, id_ex_rd!=0, and some i with id_rs_used[i] and id_rs[i]==id_ex_rd.
  - mem_busy = (ex_mem_memread | ex_mem_memwrite) & !dmem_ready.
- FSM states: RUN, LU_STALL, MEM_WAIT.
  - Registers: bubble counter cnt (3 bits), return-state bit ret_lu, wait counter wcnt.
- RUN:
  - If mem_busy: pipe_hold=1, pc_write=0, if_id_write=0, id_ex_bubble=0. Go to MEM_WAIT with ret_lu=0 and wcnt=1. mem_busy outranks lu_hit.
  - Else if lu_hit: pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_LAT>1, go to LU_STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
  - Else: pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_hold=0.
- LU_STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt decrements each cycle; at cnt==1 the next state is RUN.
  - lu_hit is not re-evaluated in this state.
  - If mem_busy: hold outputs as in MEM_WAIT, go to MEM_WAIT with ret_lu=1, cnt frozen.
- MEM_WAIT:
  - Outputs: pipe_hold=1, pc_write=0, if_id_write=0, id_ex_bubble=0 while mem_busy; wcnt increments, saturating.
  - When wcnt reaches WAIT_TIMEOUT: mem_err is set and stays set until reset. Waiting continues; there is no abort.
  - The cycle mem_busy drops, outputs are those of the return state (Mealy); next state is LU_STALL if ret_lu, else RUN. wcnt clears.
- Register file is write-through, so no forwarding path is needed past WB.
- Reset:
  - On the clk edge with reset=1: state=RUN, cnt=0, ret_lu=0, wcnt=0, mem_err=0.
  - reset overrides any state, including mid LU_STALL or MEM_WAIT.
  - Post-reset outputs with idle inputs: forward_sel=0, pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_hold=0, mem_err=0.
- Operands with id_rs_used=0 never cause a stall.
- Address 0 never forwards or stalls.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three outputs:
  - stall_cycles (32): cycles with id_ex_bubble=1.
  - hold_cycles (32): cycles with pipe_hold=1.
  - fwd_events (32): cycles where any forward_sel!=00.
- All three saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ex_rs[0]=5, ex_mem_rd=5/regwrite=1, mem_wb_rd=5/regwrite=1 -> forward_sel[1:0]=10. Same with ex_mem_rd=0 -> 01.
- id_ex_memread=1, id_ex_rd=7, id_rs[1]=7, used=2'b10, LOAD_LAT=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Same with used=2'b01 -> no stall.
- LOAD_LAT=3, load-use on x9 -> exactly 3 consecutive bubble cycles, then pc_write=1.
- LOAD_LAT=3, ex_mem_memread=1 with dmem_ready=0 for 4 cycles starting at the 2nd bubble -> pipe_hold=1 for 4 cycles, then 2 remaining bubbles, then RUN.
- WAIT_TIMEOUT=8, store in MEM, dmem_ready=0 for 10 cycles -> mem_err rises after the 8th wait cycle and stays 1 after ready. reset -> mem_err=0.
- Assert reset mid LU_STALL -> next cycle state RUN, pc_write=1, id_ex_bubble=0. With HAZARD_PERF_EN, stall_cycles=0.
